// File: rtl/pipe_stage_pkg.sv
// ============================================================================
// Module      : pipe_stage_pkg
// Description : Shared constants and state encoding for the elastic pipeline
//               stage register (pipe_stage).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_stage_pkg;

  // Width of the ID/EX bundle: inst 32 + inst_addr 32 + op1 32 + op2 32 +
  // rd_addr 5 + reg_wen 1.
  localparam int unsigned ID_EX_W = 134;

  // Canonical RISC-V NOP (addi x0, x0, 0), placed in the top 32 bits of a
  // bubble payload so a flushed/empty slot decodes as a harmless instruction.
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // Occupancy states; the encoding doubles as the entry count.
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } ps_state_e;

endpackage : pipe_stage_pkg

`default_nettype wire

// File: rtl/pipe_stage.sv
// ============================================================================
// Module      : pipe_stage
// Description : Parametrised elastic pipeline register with valid/ready
//               handshake, optional 2-entry skid buffer (registered ready),
//               synchronous flush and bubble payload on empty slots.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage
  import pipe_stage_pkg::*;
#(
  parameter int unsigned       DATA_W     = ID_EX_W,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {INST_NOP, {(DATA_W-32){1'b0}}},
  parameter bit                SKID       = 1'b1
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active low
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o
);

  logic w_push;
  logic w_pop;

  // Handshake qualifiers shared by both storage variants.
  assign w_push = in_valid_i & in_ready_o;
  assign w_pop  = out_valid_o & out_ready_i;

  generate
    if (SKID) begin : g_skid
      ps_state_e         r_state;
      logic [DATA_W-1:0] r_main;
      logic [DATA_W-1:0] r_skid;
      logic              r_valid;
      logic              r_ready;

      // Occupancy FSM: main register feeds the outputs, skid register
      // absorbs the one extra beat accepted while ready is still registered.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_state <= PS_EMPTY;
          r_main  <= BUBBLE_VAL;
          r_skid  <= BUBBLE_VAL;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
        end else if (flush_i) begin
          r_state <= PS_EMPTY;
          r_main  <= BUBBLE_VAL;
          r_skid  <= BUBBLE_VAL;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
        end else begin
          case (r_state)
            PS_EMPTY: begin
              if (w_push) begin
                r_state <= PS_ONE;
                r_main  <= in_data_i;
                r_valid <= 1'b1;
              end
            end
            PS_ONE: begin
              if (w_push && w_pop) begin
                r_main <= in_data_i;
              end else if (w_push) begin
                r_state <= PS_FULL;
                r_skid  <= in_data_i;
                r_ready <= 1'b0;
              end else if (w_pop) begin
                r_state <= PS_EMPTY;
                r_main  <= BUBBLE_VAL;
                r_valid <= 1'b0;
              end
            end
            PS_FULL: begin
              // Ready is low here, so no push can coincide with the pop.
              if (w_pop) begin
                r_state <= PS_ONE;
                r_main  <= r_skid;
                r_skid  <= BUBBLE_VAL;
                r_ready <= 1'b1;
              end
            end
            default: begin
              r_state <= PS_EMPTY;
              r_main  <= BUBBLE_VAL;
              r_skid  <= BUBBLE_VAL;
              r_valid <= 1'b0;
              r_ready <= 1'b1;
            end
          endcase
        end
      end

      // Ready is registered; flush masks it so a dropped beat is never
      // presented as accepted.
      assign in_ready_o  = r_ready & ~flush_i;
      assign out_valid_o = r_valid;
      assign out_data_o  = r_main;
      assign count_o     = r_state;
    end else begin : g_single
      logic [DATA_W-1:0] r_main;
      logic              r_valid;

      // Single-entry register: refill on push, drain to bubble on lone pop.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_main  <= BUBBLE_VAL;
          r_valid <= 1'b0;
        end else if (flush_i) begin
          r_main  <= BUBBLE_VAL;
          r_valid <= 1'b0;
        end else if (w_push) begin
          r_main  <= in_data_i;
          r_valid <= 1'b1;
        end else if (w_pop) begin
          r_main  <= BUBBLE_VAL;
          r_valid <= 1'b0;
        end
      end

      // Combinational ready lets a pop and a push share one cycle.
      assign in_ready_o  = ~r_valid | out_ready_i;
      assign out_valid_o = r_valid;
      assign out_data_o  = r_main;
      assign count_o     = {1'b0, r_valid};
    end
  endgenerate

endmodule : pipe_stage

`default_nettype wire

// File: tb/tb_pipe_stage.sv
// ============================================================================
// Module      : tb_pipe_stage
// Description : Self-checking bench for pipe_stage; drives a SKID=1 and a
//               SKID=0 instance with shared stimulus and compares both against
//               queue-based reference models.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pipe_stage;

  localparam int W = 134;
  localparam logic [W-1:0] C_BUBBLE = {32'h0000_0013, 102'b0};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;

  logic         s_in_ready, s_out_valid;
  logic [W-1:0] s_out_data;
  logic [1:0]   s_count;
  logic         d_in_ready, d_out_valid;
  logic [W-1:0] d_out_data;
  logic [1:0]   d_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference contents of each stage, oldest first.
  logic [W-1:0] q_s[$];
  logic [W-1:0] q_d[$];

  always #5 clk = ~clk;

  pipe_stage #(.DATA_W(W), .SKID(1'b1)) u_dut_skid (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (s_in_ready),
    .in_data_i  (in_data),
    .out_valid_o(s_out_valid),
    .out_ready_i(out_ready),
    .out_data_o (s_out_data),
    .count_o    (s_count)
  );

  pipe_stage #(.DATA_W(W), .SKID(1'b0)) u_dut_single (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (d_in_ready),
    .in_data_i  (in_data),
    .out_valid_o(d_out_valid),
    .out_ready_i(out_ready),
    .out_data_o (d_out_data),
    .count_o    (d_count)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_data();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  // Compare every output of both instances against the reference queues.
  task automatic check_outputs();
    int ns, nd;
    ns = q_s.size();
    nd = q_d.size();
    check("skid_ready", W'(s_in_ready), W'(!flush && ns < 2));
    check("skid_valid", W'(s_out_valid), W'(ns != 0));
    check("skid_data", s_out_data, (ns != 0) ? q_s[0] : C_BUBBLE);
    check("skid_count", W'(s_count), W'(ns));
    check("single_ready", W'(d_in_ready), W'(nd == 0 || out_ready));
    check("single_valid", W'(d_out_valid), W'(nd != 0));
    check("single_data", d_out_data, (nd != 0) ? q_d[0] : C_BUBBLE);
    check("single_count", W'(d_count), W'(nd));
  endtask

  // One cycle: drive inputs after the falling edge, check, then advance the
  // models to what the next rising edge must produce.
  task automatic step(input bit v, input logic [W-1:0] d, input bit ordy, input bit fl);
    bit rs, rd;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_outputs();
    if (rst) begin
      rs = !fl && (q_s.size() < 2);
      rd = (q_d.size() == 0) || ordy;
      if (fl) begin
        q_s.delete();
        q_d.delete();
      end else begin
        if (q_s.size() > 0 && ordy) void'(q_s.pop_front());
        if (v && rs) q_s.push_back(d);
        if (q_d.size() > 0 && ordy) void'(q_d.pop_front());
        if (v && rd) q_d.push_back(d);
      end
    end
  endtask

  initial begin
    // Reset held with a valid payload present: nothing may be captured.
    step(1'b1, W'(16'h1234), 1'b0, 1'b0);
    step(1'b1, W'(16'h1234), 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b1, W'(16'h1234), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Backpressure: A, B fill the skid stage, C waits upstream.
    step(1'b1, W'(32'hA), 1'b0, 1'b0);
    step(1'b1, W'(32'hB), 1'b0, 1'b0);
    step(1'b1, W'(32'hC), 1'b0, 1'b0);
    step(1'b1, W'(32'hC), 1'b1, 1'b0);
    step(1'b1, W'(32'hC), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush while full, with a competing push of D.
    step(1'b1, W'(32'hA1), 1'b0, 1'b0);
    step(1'b1, W'(32'hB1), 1'b0, 1'b0);
    step(1'b1, W'(32'hD1), 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Single-entry replacement: stalled entry, then pop and push together.
    step(1'b1, W'(32'hE0), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, W'(32'hF0), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset while the skid stage is full.
    step(1'b1, W'(32'hAA), 1'b0, 1'b0);
    step(1'b1, W'(32'hBB), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    q_s.delete();
    q_d.delete();
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, rand_data(), ($urandom % 3) != 0, ($urandom % 20) == 0);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pipe_stage

`default_nettype wire
